// File: rtl/arb_pkg.sv
// Shared constants and state type for the mux select arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_priority_pick.sv
// Rotated priority encoder: first set request after i_last, wrapping modulo NUM_REQ.
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_last,
  output logic               o_any,
  output logic [SEL_W-1:0]   o_winner
);

  logic [SEL_W-1:0] w_idx;

  assign o_any = |i_req;

  // Walk from the farthest offset to the nearest so the nearest set bit wins.
  always_comb begin
    w_idx    = '0;
    o_winner = '0;
    for (int k = int'(NUM_REQ); k > 0; k--) begin
      w_idx = i_last + SEL_W'(k);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
      end
    end
  end

endmodule : rr_priority_pick

// File: rtl/mux_select_arbiter.sv
// Round-robin owner arbiter driving the select of a shared 8:1 datapath mux.
// Define ARB_HOLD_LIMIT_EN to cap consecutive ownership at MAX_HOLD cycles while others wait.
module mux_select_arbiter
  import arb_pkg::*;
`ifdef ARB_HOLD_LIMIT_EN
#(
  parameter int unsigned MAX_HOLD = 15
)
`endif
(
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [SEL_W-1:0]   o_select,
  output logic               o_valid
);

  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [SEL_W-1:0]   r_select;
  logic [SEL_W-1:0]   r_last;
  logic               r_valid;

  logic               w_any;
  logic [SEL_W-1:0]   w_winner;
  logic               w_force;
  logic               w_hold;

  rr_priority_pick u_pick (
    .i_req    (i_req),
    .i_last   (r_last),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              w_others;

  assign w_others = |(i_req & ~(NUM_REQ'(1) << r_select));
  assign w_force  = (r_hold_cnt == HOLD_W'(MAX_HOLD)) && w_others;

  // Counts owned cycles; restarts at 1 on every new grant, saturates when unchallenged.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_hold_cnt <= '0;
    end else if (w_hold) begin
      if (r_hold_cnt != HOLD_W'(MAX_HOLD)) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end
    end else if (w_any) begin
      r_hold_cnt <= HOLD_W'(1);
    end else begin
      r_hold_cnt <= '0;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  assign w_hold = (r_state == ARB_OWNED) && i_req[r_select] && !w_force;

  // Owner FSM: hold while requested, otherwise re-arbitrate or go idle in the same edge.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= ARB_IDLE;
      r_grant  <= '0;
      r_select <= '0;
      r_last   <= SEL_W'(NUM_REQ - 1);
      r_valid  <= 1'b0;
    end else if (!w_hold) begin
      if (w_any) begin
        r_state  <= ARB_OWNED;
        r_grant  <= NUM_REQ'(1) << w_winner;
        r_select <= w_winner;
        r_last   <= w_winner;
        r_valid  <= 1'b1;
      end else begin
        r_state <= ARB_IDLE;
        r_grant <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_grant  = r_grant;
  assign o_select = r_select;
  assign o_valid  = r_valid;

endmodule : mux_select_arbiter

// File: tb/tb_mux_select_arbiter.sv
// Self-checking bench for mux_select_arbiter against a behavioural round-robin model.
module tb_mux_select_arbiter;

`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] m_grant;
  int         m_select;
  logic       m_valid;
  int         m_last;
  int         m_cnt;

  always #5 clk = ~clk;

`ifdef ARB_HOLD_LIMIT_EN
  mux_select_arbiter #(.MAX_HOLD(MAXH)) dut (
`else
  mux_select_arbiter dut (
`endif
    .i_clock  (clk),
    .i_reset  (rst_n),
    .i_req    (req),
    .o_grant  (grant),
    .o_select (sel),
    .o_valid  (valid)
  );

  task automatic model_reset();
    m_grant  = 8'h00;
    m_select = 0;
    m_valid  = 1'b0;
    m_last   = 7;
    m_cnt    = 0;
  endtask

  // One rising edge: advance the model with the sampled requests, then settle.
  task automatic tick();
    int  win;
    bit  frc;
    int  others;
    @(posedge clk);
    win    = -1;
    frc    = 1'b0;
    others = int'(req) & ~(1 << m_select) & 255;
    if (HOLD_EN && m_valid && m_cnt == MAXH && others != 0) frc = 1'b1;
    if (m_valid && req[m_select] && !frc) begin
      if (m_cnt < MAXH) m_cnt++;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        if (win < 0 && req[(m_last + k) % 8]) win = (m_last + k) % 8;
      end
      if (win >= 0) begin
        m_grant  = 8'(1 << win);
        m_select = win;
        m_last   = win;
        m_valid  = 1'b1;
        m_cnt    = 1;
      end else begin
        m_grant = 8'h00;
        m_valid = 1'b0;
        m_cnt   = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    model_reset();
    #13;
    checks++;
    if (grant !== 8'h00) begin errors++; $display("FAIL reset_grant got=%h want=00", grant); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid); end
    checks++;
    if (sel !== 3'd0) begin errors++; $display("FAIL reset_select got=%0d want=0", sel); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({grant, sel, valid} !== {8'h01, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_first_edge got=%h/%0d/%b want=01/0/1", grant, sel, valid);
    end
  endtask

  task automatic test_rotation();
    int         held [8];
    logic [7:0] drop;
    logic [7:0] prev;
    logic [7:0] order [$];
    logic [7:0] exp_order [4];
    exp_order = '{8'h01, 8'h08, 8'h20, 8'h01};
    do_reset();
    foreach (held[i]) held[i] = 0;
    drop = 8'h00;
    prev = 8'h00;
    for (int c = 0; c < 8; c++) begin
      req = 8'h29 & ~drop;
      tick();
      checks++;
      if (grant !== m_grant || valid !== m_valid) begin
        errors++;
        $display("FAIL rotation_model c=%0d got=%h want=%h", c, grant, m_grant);
      end
      checks++;
      if (grant === 8'h00) begin errors++; $display("FAIL rotation_gap c=%0d got=00 want=nonzero", c); end
      if (grant !== prev) order.push_back(grant);
      prev = grant;
      drop = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (grant[i]) begin
          held[i]++;
          if (held[i] == 2) begin drop[i] = 1'b1; held[i] = 0; end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= order.size() || order[i] !== exp_order[i]) begin
        errors++;
        $display("FAIL rotation_order idx=%0d got=%h want=%h", i,
                 (i < order.size()) ? order[i] : 8'hxx, exp_order[i]);
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req = 8'h04 | ((c >= 2) ? 8'h40 : 8'h00);
      tick();
      checks++;
      if (grant !== 8'h04 || sel !== 3'd2) begin
        errors++;
        $display("FAIL lock_hold c=%0d got=%h/%0d want=04/2", c, grant, sel);
      end
    end
    req = 8'h40;
    tick();
    checks++;
    if (grant !== 8'h40 || sel !== 3'd6 || valid !== 1'b1) begin
      errors++;
      $display("FAIL lock_release got=%h/%0d want=40/6", grant, sel);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seq_req [4];
    logic [7:0] seq_exp [4];
    seq_req = '{8'h80, 8'h01, 8'h81, 8'h80};
    seq_exp = '{8'h80, 8'h01, 8'h01, 8'h80};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req = seq_req[i];
      tick();
      checks++;
      if (grant !== seq_exp[i] || grant !== m_grant) begin
        errors++;
        $display("FAIL wrap step=%0d got=%h want=%h", i, grant, seq_exp[i]);
      end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    req = 8'h10;
    tick();
    checks++;
    if (grant !== 8'h10) begin errors++; $display("FAIL midreset_setup got=%h want=10", grant); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (grant !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async got=%h/%b want=00/0", grant, valid);
    end
    req = 8'h11;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant !== 8'h01 || sel !== 3'd0) begin
      errors++;
      $display("FAIL midreset_after got=%h/%0d want=01/0", grant, sel);
    end
  endtask

  task automatic test_hold_limit();
    logic [7:0] exp;
    do_reset();
    req = 8'h03;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (HOLD_EN) exp = (((c - 1) / MAXH) % 2 == 1) ? 8'h02 : 8'h01;
      else         exp = 8'h01;
      checks++;
      if (grant !== exp) begin
        errors++;
        $display("FAIL hold_limit c=%0d got=%h want=%h", c, grant, exp);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 1) == 1) req = 8'($urandom_range(0, 255));
        else req = req ^ 8'(1 << $urandom_range(0, 7));
      end
      tick();
      checks++;
      if (grant !== m_grant || valid !== m_valid || (m_valid && sel !== 3'(m_select))) begin
        errors++;
        $display("FAIL random c=%0d req=%h got=%h/%0d/%b want=%h/%0d/%b",
                 c, req, grant, sel, valid, m_grant, m_select, m_valid);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    test_reset();
    test_rotation();
    test_lock();
    test_wrap();
    test_midreset();
    test_hold_limit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_select_arbiter
